photon_detector_frontend: RTL

Upstream conditioning stage for photon_fsm. It takes six raw, asynchronous single-photon detector lines and synchronises each one, then edge-detects it. Each channel then runs a per-channel hold/dead-time state machine. The block drives clean, stretched S1..S6 levels straight into photon_fsm. It also reports per-event click information and a saturating event counter.

---
 rtl/photon_detector_frontend_if.sv | 51 +++++
 rtl/photon_detector_frontend.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/photon_detector_frontend_if.sv
// Purpose: bundles the detector inputs and conditioned outputs of photon_detector_frontend.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a plain level or a one-cycle pulse.
interface photon_detector_frontend_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       det_raw;
    logic             clear_cnt;
    logic             S1;
    logic             S2;
    logic             S3;
    logic             S4;
    logic             S5;
    logic             S6;
    logic             click_valid;
    logic [5:0]       click_vec;
    logic             multi_click;
    logic [CNT_W-1:0] click_count;

    // Upstream side: drives the raw detector lines and the counter clear.
    modport master (
        output det_raw,
        output clear_cnt,
        input  S1,
        input  S2,
        input  S3,
        input  S4,
        input  S5,
        input  S6,
        input  click_valid,
        input  click_vec,
        input  multi_click,
        input  click_count
    );

    // Frontend side: conditions the detector lines and reports click events.
    modport slave (
        input  det_raw,
        input  clear_cnt,
        output S1,
        output S2,
        output S3,
        output S4,
        output S5,
        output S6,
        output click_valid,
        output click_vec,
        output multi_click,
        output click_count
    );
endinterface

// File: rtl/photon_detector_frontend.sv
// Purpose: sync, edge-detect and hold/dead-time shape six detector lines into S1..S6 plus click reporting.
// Latency: det_raw first sampled high at edge n gives S_k and click_valid high after edge n+2.
// Backpressure: none; rises arriving in HOLD or DEAD are dropped, click_count saturates.
module photon_detector_frontend #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEAD_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    photon_detector_frontend_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DEAD = 2'd2
    } ch_state_t;

    localparam int          NCH       = 6;
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]  DEAD_LOAD = 8'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchroniser chain; sync2_d only exists to form the rising-edge strobe.
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] sync2_d;
    logic [NCH-1:0] rise;

    // Per-channel state and down-counter.
    ch_state_t      state_q [NCH];
    ch_state_t      state_d [NCH];
    logic [7:0]     cnt_q   [NCH];
    logic [7:0]     cnt_d   [NCH];

    // Channels leaving IDLE on the coming edge.
    logic [NCH-1:0] enter;
    logic           enter_any;
    logic           enter_multi;

    // Registered click report.
    logic             click_valid_q;
    logic [NCH-1:0]   click_vec_q;
    logic             multi_click_q;
    logic [CNT_W-1:0] click_count_q;

    // Two-flop synchroniser plus delay flop for every detector line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
        end else begin
            sync1   <= bus.det_raw;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

    // Channel state registers; reset aborts any HOLD or DEAD in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Next-state logic per channel; a rise only counts when the channel is IDLE.
    always_comb begin
        enter = '0;
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                IDLE: begin
                    if (rise[k]) begin
                        state_d[k] = HOLD;
                        cnt_d[k]   = HOLD_LOAD;
                        enter[k]   = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q[k] == 8'd0) begin
                        state_d[k] = DEAD;
                        cnt_d[k]   = DEAD_LOAD;
                    end else begin
                        cnt_d[k]   = cnt_q[k] - 8'd1;
                    end
                end
                DEAD: begin
                    if (cnt_q[k] == 8'd0) begin
                        state_d[k] = IDLE;
                    end else begin
                        cnt_d[k]   = cnt_q[k] - 8'd1;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    cnt_d[k]   = 8'd0;
                end
            endcase
        end
    end

    assign enter_any   = |enter;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign enter_multi = |(enter & (enter - 6'd1));

    // Click report is registered so it lines up with the first HOLD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            click_valid_q <= 1'b0;
            click_vec_q   <= '0;
            multi_click_q <= 1'b0;
        end else begin
            click_valid_q <= enter_any;
            click_vec_q   <= enter;
            multi_click_q <= enter_multi;
        end
    end

    // Event counter counts reported events, not channels; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            click_count_q <= '0;
        end else if (bus.clear_cnt) begin
            click_count_q <= '0;
        end else if (enter_any && (click_count_q != CNT_MAX)) begin
            click_count_q <= click_count_q + 1'b1;
        end
    end

    assign bus.S1          = (state_q[0] == HOLD);
    assign bus.S2          = (state_q[1] == HOLD);
    assign bus.S3          = (state_q[2] == HOLD);
    assign bus.S4          = (state_q[3] == HOLD);
    assign bus.S5          = (state_q[4] == HOLD);
    assign bus.S6          = (state_q[5] == HOLD);
    assign bus.click_valid = click_valid_q;
    assign bus.click_vec   = click_vec_q;
    assign bus.multi_click = multi_click_q;
    assign bus.click_count = click_count_q;

endmodule
